health_controller: RTL and testbench
====================================

HEALTH_CONTROLLER -- requirements
Module: health_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLOCK and RESET.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- MAX_HEALTH, 100, ceiling of health_level.
- START_HEALTH, 100, health_level after reset.
- INVULN_TICKS, 8, ticks of damage immunity after a hit or revive.
- REGEN_PERIOD, 20, ticks without damage between regeneration steps.
- REGEN_AMOUNT, 1, health added per regeneration step.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- CLOCK, in, 1, system clock.
- RESET, in, 1, synchronous active-high reset.
- tick, in, 1, one-cycle time-base strobe (e.g. 10 Hz).
- damage_pulse, in, 1, one-cycle damage request.
- damage_amount, in, 7, damage magnitude (0-127).
- heal_pulse, in, 1, one-cycle heal request.
- heal_amount, in, 7, heal magnitude (0-127).
- revive, in, 1, one-cycle revive request.
- health_level, out, 32, current health, 0..MAX_HEALTH, upper bits always zero; drives the health bar's health_level input.
- state, out, 2, 0=ALIVE, 1=INVULN, 2=DEAD (3 is never driven).
- dead, out, 1, high iff state==DEAD.
- hit_flash, out, 1, high during INVULN on ticks with odd remaining count (blink cue for display).

Function
REQ-004 All outputs SHALL be registered, with 1-cycle latency from an input pulse to the updated health_level/state.
REQ-005 Health arithmetic SHALL use at least 8-bit internal width and saturate to the range 0..MAX_HEALTH; it SHALL never wrap.
REQ-006 ALIVE + damage_pulse: health SHALL become max(health-damage_amount,0); if the result is 0, go to DEAD, else go to INVULN with inv_cnt=INVULN_TICKS.
REQ-007 damage_pulse with damage_amount==0 SHALL be ignored (no state change).
REQ-008 damage_pulse SHALL be ignored in INVULN and DEAD.
REQ-009 heal_pulse in ALIVE or INVULN SHALL set health to min(health+heal_amount,MAX_HEALTH); in DEAD it SHALL be ignored.
REQ-010 Simultaneous damage_pulse and heal_pulse in ALIVE: damage SHALL be evaluated first; if damage reaches 0 then DEAD and the heal is discarded, else the heal is applied to the post-damage value in the same cycle.
REQ-011 INVULN: on each tick, inv_cnt SHALL decrement; when a tick arrives with inv_cnt==1, go to ALIVE (inv_cnt=0).
REQ-012 Regeneration: in ALIVE only, regen_cnt SHALL increment per tick; on reaching REGEN_PERIOD, add REGEN_AMOUNT (saturating) and clear regen_cnt; regen_cnt SHALL clear on any accepted damage and hold at 0 outside ALIVE.
REQ-013 A regen step and a heal in the same cycle SHALL both apply (sum, then saturate).
REQ-014 DEAD + revive: health SHALL become MAX_HEALTH and state INVULN with inv_cnt=INVULN_TICKS; revive SHALL be ignored in other states.
REQ-015 hit_flash SHALL be 0 outside INVULN.

Reset
REQ-016 While RESET is high at a CLOCK edge: health_level=START_HEALTH, state=ALIVE, dead=0, hit_flash=0, inv_cnt=0, regen_cnt=0; RESET SHALL override all other inputs, including mid-INVULN and DEAD.

Verification
REQ-017 Reset, then damage 30 -> next cycle health_level=70, state=INVULN; 8 ticks later state=ALIVE.
REQ-018 In INVULN, damage 50 -> health_level stays 70; after 8 ticks a heal of 50 -> health_level=100 (saturated).
REQ-019 Health 10 ALIVE, damage 40 plus simultaneous heal 90 -> health_level=0, state=DEAD, dead=1.
REQ-020 DEAD, heal 20 -> no change; revive -> health_level=100, state=INVULN.
REQ-021 Health 95 ALIVE, 20 ticks with no damage -> health_level=96; damage 1 at tick 19 of the next period -> regen_cnt cleared, and no regen before 20 further ALIVE ticks.
REQ-022 RESET asserted during INVULN with health 40 -> next cycle health_level=100, state=ALIVE, hit_flash=0.

Source files
------------

// File: rtl/health_controller.sv
// health_controller
//   Tracks a health value with damage, heal, regeneration, a timed
//   invulnerability window after a hit or revive, and a DEAD state that
//   only a revive leaves.
//
//   Ports
//     CLOCK          system clock
//     RESET          synchronous, active-high reset
//     tick           one-cycle time-base strobe
//     damage_pulse   one-cycle damage request, magnitude on damage_amount
//     heal_pulse     one-cycle heal request, magnitude on heal_amount
//     revive         one-cycle revive request (acts only in DEAD)
//     health_level   current health, 0..MAX_HEALTH, zero-extended to 32 bits
//     state          0=ALIVE, 1=INVULN, 2=DEAD
//     dead           high iff state is DEAD
//     hit_flash      blink cue, high in INVULN while the remaining count is odd
//
//   State   | meaning
//   --------+---------------------------------------------------------
//   ALIVE   | takes damage; regenerates every REGEN_PERIOD ticks
//   INVULN  | ignores damage; counts down INVULN_TICKS ticks to ALIVE
//   DEAD    | health 0; ignores damage/heal, waits for revive
//
//   Health is held in 8 bits, so MAX_HEALTH must not exceed 255.
//   All arithmetic is carried out in 32 bits and clamped, so it cannot wrap.

module health_controller #(
    parameter int MAX_HEALTH   = 100,
    parameter int START_HEALTH = 100,
    parameter int INVULN_TICKS = 8,
    parameter int REGEN_PERIOD = 20,
    parameter int REGEN_AMOUNT = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        tick,
    input  logic        damage_pulse,
    input  logic [6:0]  damage_amount,
    input  logic        heal_pulse,
    input  logic [6:0]  heal_amount,
    input  logic        revive,
    output logic [31:0] health_level,
    output logic [1:0]  state,
    output logic        dead,
    output logic        hit_flash
);

    localparam int IW = $clog2(INVULN_TICKS + 1);
    localparam int RW = $clog2(REGEN_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_health;
    logic [7:0]      w_health_nxt;
    logic [IW-1:0]   r_inv_cnt;
    logic [IW-1:0]   w_inv_nxt;
    logic [RW-1:0]   r_regen_cnt;
    logic [RW-1:0]   w_regen_nxt;
    logic            r_dead;
    logic            r_hit_flash;

    logic            w_dmg_ok;
    logic [31:0]     w_health_ext;
    logic [31:0]     w_dmg_ext;
    logic [31:0]     w_heal_ext;
    logic [31:0]     w_add;

    function automatic logic [7:0] sat_add(input logic [31:0] base, input logic [31:0] add);
        logic [31:0] s;
        s = base + add;
        return (s > 32'(MAX_HEALTH)) ? 8'(MAX_HEALTH) : s[7:0];
    endfunction

    assign w_health_ext = {24'd0, r_health};
    assign w_dmg_ext    = {25'd0, damage_amount};
    assign w_heal_ext   = heal_pulse ? {25'd0, heal_amount} : 32'd0;
    // A zero-magnitude hit is treated as no hit at all.
    assign w_dmg_ok     = damage_pulse && (damage_amount != 7'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_health_nxt = r_health;
        w_inv_nxt    = r_inv_cnt;
        w_regen_nxt  = r_regen_cnt;
        w_add        = 32'd0;

        case (r_state)
            ST_ALIVE: begin
                if (w_dmg_ok) begin
                    w_regen_nxt = '0;
                    if (w_dmg_ext >= w_health_ext) begin
                        // Lethal hit: any simultaneous heal is discarded.
                        w_state_nxt  = ST_DEAD;
                        w_health_nxt = 8'd0;
                    end else begin
                        w_state_nxt  = ST_INVULN;
                        w_inv_nxt    = IW'(INVULN_TICKS);
                        w_health_nxt = sat_add(w_health_ext - w_dmg_ext, w_heal_ext);
                    end
                end else begin
                    w_add = w_heal_ext;
                    if (tick) begin
                        if (r_regen_cnt == RW'(REGEN_PERIOD - 1)) begin
                            w_regen_nxt = '0;
                            w_add       = w_heal_ext + 32'(REGEN_AMOUNT);
                        end else begin
                            w_regen_nxt = r_regen_cnt + RW'(1);
                        end
                    end
                    w_health_nxt = sat_add(w_health_ext, w_add);
                end
            end

            ST_INVULN: begin
                w_regen_nxt  = '0;
                w_health_nxt = sat_add(w_health_ext, w_heal_ext);
                if (tick) begin
                    if (r_inv_cnt == IW'(1)) begin
                        w_state_nxt = ST_ALIVE;
                        w_inv_nxt   = '0;
                    end else begin
                        w_inv_nxt = r_inv_cnt - IW'(1);
                    end
                end
            end

            ST_DEAD: begin
                w_regen_nxt = '0;
                if (revive) begin
                    w_state_nxt  = ST_INVULN;
                    w_health_nxt = 8'(MAX_HEALTH);
                    w_inv_nxt    = IW'(INVULN_TICKS);
                end
            end

            default: begin
                w_state_nxt  = ST_ALIVE;
                w_inv_nxt    = '0;
                w_regen_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= ST_ALIVE;
            r_health    <= 8'(START_HEALTH);
            r_inv_cnt   <= '0;
            r_regen_cnt <= '0;
            r_dead      <= 1'b0;
            r_hit_flash <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_health    <= w_health_nxt;
            r_inv_cnt   <= w_inv_nxt;
            r_regen_cnt <= w_regen_nxt;
            r_dead      <= (w_state_nxt == ST_DEAD);
            r_hit_flash <= (w_state_nxt == ST_INVULN) && w_inv_nxt[0];
        end
    end

    assign health_level = {24'd0, r_health};
    assign state        = r_state;
    assign dead         = r_dead;
    assign hit_flash    = r_hit_flash;

endmodule

// File: tb/tb_health_controller.sv
module tb_health_controller;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        tick = 1'b0;
    logic        damage_pulse = 1'b0;
    logic [6:0]  damage_amount = '0;
    logic        heal_pulse = 1'b0;
    logic [6:0]  heal_amount = '0;
    logic        revive = 1'b0;
    logic [31:0] health_level;
    logic [1:0]  state;
    logic        dead;
    logic        hit_flash;

    health_controller dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .tick          (tick),
        .damage_pulse  (damage_pulse),
        .damage_amount (damage_amount),
        .heal_pulse    (heal_pulse),
        .heal_amount   (heal_amount),
        .revive        (revive),
        .health_level  (health_level),
        .state         (state),
        .dead          (dead),
        .hit_flash     (hit_flash)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] h;
        logic [1:0]  st;
        logic        d;
        logic        f;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model state
    int m_h = 100;
    int m_st = 0;
    int m_inv = 0;
    int m_rc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit rst, input bit tk, input bit dp, input int da,
                              input bit hp, input int ha, input bit rv);
        int add;
        if (rst) begin
            m_h = 100; m_st = 0; m_inv = 0; m_rc = 0;
        end else begin
            case (m_st)
                0: begin
                    if (dp && da > 0) begin
                        m_rc = 0;
                        m_h  = m_h - da;
                        if (m_h <= 0) begin
                            m_h = 0; m_st = 2;
                        end else begin
                            m_st = 1; m_inv = 8;
                            if (hp) m_h = imin(m_h + ha, 100);
                        end
                    end else begin
                        add = hp ? ha : 0;
                        if (tk) begin
                            m_rc++;
                            if (m_rc == 20) begin
                                add  = add + 1;
                                m_rc = 0;
                            end
                        end
                        m_h = imin(m_h + add, 100);
                    end
                end
                1: begin
                    if (hp) m_h = imin(m_h + ha, 100);
                    if (tk) begin
                        m_inv--;
                        if (m_inv == 0) m_st = 0;
                    end
                end
                default: begin
                    if (rv) begin
                        m_h = 100; m_st = 1; m_inv = 8;
                    end
                end
            endcase
        end
    endtask

    // One clock of stimulus: drive, push expectation, pop and compare after the edge.
    task automatic cyc(input bit rst, input bit tk, input bit dp, input int da,
                       input bit hp, input int ha, input bit rv);
        exp_t e;
        @(negedge CLOCK);
        RESET = rst; tick = tk; damage_pulse = dp; damage_amount = 7'(da);
        heal_pulse = hp; heal_amount = 7'(ha); revive = rv;
        model_step(rst, tk, dp, da, hp, ha, rv);
        e.h = 32'(m_h); e.st = 2'(m_st); e.d = (m_st == 2);
        e.f = (m_st == 1) && (m_inv % 2 == 1);
        q_exp.push_back(e);
        @(posedge CLOCK);
        #1;
        if (q_exp.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            chk("health", health_level, e.h);
            chk("state", {30'd0, state}, {30'd0, e.st});
            chk("dead", {31'd0, dead}, {31'd0, e.d});
            chk("hit_flash", {31'd0, hit_flash}, {31'd0, e.f});
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            idle();
        end
    endtask

    task automatic dmg(input int a);
        cyc(0, 0, 1, a, 0, 0, 0);
    endtask

    task automatic heal(input int a);
        cyc(0, 0, 0, 0, 1, a, 0);
    endtask

    task automatic exp_hs(input string tag, input int h, input int st);
        chk({tag, "_h"}, health_level, 32'(h));
        chk({tag, "_st"}, {30'd0, state}, 32'(st));
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 50, 1, 10, 1);
        exp_hs("reset", 100, 0);
        chk("reset_flash", {31'd0, hit_flash}, 32'd0);
        idle();

        // hit, ignored hit while invulnerable, countdown, saturating heal
        dmg(30);
        exp_hs("dmg30", 70, 1);
        dmg(50);
        exp_hs("invuln_dmg", 70, 1);
        ticks(7);
        exp_hs("invuln_7", 70, 1);
        ticks(1);
        exp_hs("invuln_end", 70, 0);
        heal(50);
        exp_hs("heal_sat", 100, 0);

        // lethal hit with simultaneous heal
        dmg(90);
        exp_hs("dmg90", 10, 1);
        ticks(8);
        cyc(0, 0, 1, 40, 1, 90, 0);
        exp_hs("lethal", 0, 2);
        chk("lethal_dead", {31'd0, dead}, 32'd1);

        // DEAD ignores heal and damage; revive
        heal(20);
        exp_hs("dead_heal", 0, 2);
        dmg(5);
        ticks(1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        exp_hs("revive", 100, 1);
        ticks(8);

        // regeneration period and reset of regen count by damage
        dmg(5);
        ticks(8);
        exp_hs("at95", 95, 0);
        ticks(19);
        exp_hs("regen_19", 95, 0);
        ticks(1);
        exp_hs("regen_20", 96, 0);
        ticks(18);
        cyc(0, 1, 1, 1, 0, 0, 0);
        exp_hs("dmg_at19", 95, 1);
        ticks(8);
        ticks(19);
        exp_hs("regen_clr19", 95, 0);
        ticks(1);
        exp_hs("regen_clr20", 96, 0);

        // zero damage ignored
        dmg(0);
        exp_hs("dmg0", 96, 0);

        // heal and regen step in the same cycle
        dmg(10);
        ticks(8);
        ticks(19);
        cyc(0, 1, 0, 0, 1, 5, 0);
        exp_hs("heal_regen", 92, 0);

        // reset mid-INVULN and in DEAD
        dmg(52);
        exp_hs("to40", 40, 1);
        ticks(1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        exp_hs("rst_invuln", 100, 0);
        chk("rst_invuln_flash", {31'd0, hit_flash}, 32'd0);
        dmg(127);
        exp_hs("dead127", 0, 2);
        cyc(1, 0, 0, 0, 0, 0, 1);
        exp_hs("rst_dead", 100, 0);
        chk("rst_dead_d", {31'd0, dead}, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 60)),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 127)),
                ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
